// File: rtl/ddc_phase_sequencer.sv
// ddc_phase_sequencer: shadow/active phase registers for a bank of ddc_core channels,
// with a commit sequence that loads the phases, pulses resync, and gates output until settled.
`default_nettype none

module ddc_phase_sequencer #(
   parameter int N_CH          = 8,
   parameter int LOAD_WAIT     = 8,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                                     s_axis_aclk,
   input  logic                                     s_axis_aresetn,
   input  logic                                     cfg_wr_en,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_wr_ch,
   input  logic [63:0]                              cfg_wr_data,
   input  logic                                     cfg_commit,
   output logic [N_CH*64-1:0]                       m_axis_phase_tdata,
   output logic                                     m_axis_phase_tvalid,
   output logic                                     resync,
   output logic                                     ddc_gate,
   output logic                                     busy,
   output logic [15:0]                              commit_count
);

   localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CNT_MAX = (LOAD_WAIT > SETTLE_CYCLES) ? LOAD_WAIT : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WAIT   = 3'd2,
      S_RESYNC = 3'd3,
      S_SETTLE = 3'd4,
      S_RUN    = 3'd5
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pending, pending_nxt;
   logic             seq_active;
   logic [63:0]      shadow [N_CH];
   logic [63:0]      active [N_CH];

   assign seq_active = (state == S_LOAD) || (state == S_WAIT) ||
                       (state == S_RESYNC) || (state == S_SETTLE);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      if (seq_active && cfg_commit)
         pending_nxt = 1'b1;
      case (state)
         S_IDLE, S_RUN: begin
            if (cfg_commit)
               state_nxt = S_LOAD;
         end
         S_LOAD: begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(LOAD_WAIT - 1);
         end
         S_WAIT: begin
            if (cnt == '0)
               state_nxt = S_RESYNC;
            else
               cnt_nxt = cnt - 1'b1;
         end
         S_RESYNC: begin
            state_nxt = S_SETTLE;
            cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
         end
         S_SETTLE: begin
            if (cnt == '0) begin
               // A commit landing in the last settle cycle chains straight into LOAD
               state_nxt   = (pending || cfg_commit) ? S_LOAD : S_RUN;
               pending_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_aresetn) begin
         state               <= S_IDLE;
         cnt                 <= '0;
         pending             <= 1'b0;
         m_axis_phase_tvalid <= 1'b0;
         resync              <= 1'b0;
         ddc_gate            <= 1'b0;
         busy                <= 1'b0;
         commit_count        <= '0;
         for (int k = 0; k < N_CH; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         pending  <= pending_nxt;
         resync   <= (state_nxt == S_RESYNC);
         ddc_gate <= (state_nxt == S_RUN);
         busy     <= (state_nxt == S_LOAD) || (state_nxt == S_WAIT) ||
                     (state_nxt == S_RESYNC) || (state_nxt == S_SETTLE);
         if (state == S_LOAD) begin
            // Copies the pre-edge shadow, so a write issued during LOAD waits for the next commit
            for (int k = 0; k < N_CH; k++)
               active[k] <= shadow[k];
            m_axis_phase_tvalid <= 1'b1;
            commit_count        <= commit_count + 16'd1;
         end
         for (int k = 0; k < N_CH; k++) begin
            if (cfg_wr_en && (cfg_wr_ch == CH_W'(k)))
               shadow[k] <= cfg_wr_data;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_tdata
      assign m_axis_phase_tdata[64*k +: 64] = active[k];
   end

endmodule

`default_nettype wire

// File: tb/tb_ddc_phase_sequencer.sv
// Bench for ddc_phase_sequencer: timeline model of two instances (default and short-timing,
// 5-channel) compared every cycle, plus hand-computed literal checks.
`default_nettype none

module tb_ddc_phase_sequencer;

   logic        clk = 1'b0;
   logic        rstn;
   logic        wr_en   [2];
   logic [2:0]  wr_ch   [2];
   logic [63:0] wr_data [2];
   logic        commit  [2];

   logic [511:0] tdata0;
   logic [319:0] tdata1;
   logic        tv [2];
   logic        rs [2];
   logic        gt [2];
   logic        bz [2];
   logic [15:0] cc [2];

   int n_chk  = 0;
   int n_pass = 0;
   int t      = 0;

   always #5 clk = ~clk;

   ddc_phase_sequencer dut0 (
      .s_axis_aclk        (clk),
      .s_axis_aresetn     (rstn),
      .cfg_wr_en          (wr_en[0]),
      .cfg_wr_ch          (wr_ch[0]),
      .cfg_wr_data        (wr_data[0]),
      .cfg_commit         (commit[0]),
      .m_axis_phase_tdata (tdata0),
      .m_axis_phase_tvalid(tv[0]),
      .resync             (rs[0]),
      .ddc_gate           (gt[0]),
      .busy               (bz[0]),
      .commit_count       (cc[0])
   );

   ddc_phase_sequencer #(.N_CH(5), .LOAD_WAIT(1), .SETTLE_CYCLES(1)) dut1 (
      .s_axis_aclk        (clk),
      .s_axis_aresetn     (rstn),
      .cfg_wr_en          (wr_en[1]),
      .cfg_wr_ch          (wr_ch[1]),
      .cfg_wr_data        (wr_data[1]),
      .cfg_commit         (commit[1]),
      .m_axis_phase_tdata (tdata1),
      .m_axis_phase_tvalid(tv[1]),
      .resync             (rs[1]),
      .ddc_gate           (gt[1]),
      .busy               (bz[1]),
      .commit_count       (cc[1])
   );

   // Model: a sequence is described only by the cycle index of its LOAD cycle
   int          lw_of  [2] = '{8, 1};
   int          sc_of  [2] = '{16, 1};
   int          nch_of [2] = '{8, 5};
   logic [63:0] sh  [2][8];
   logic [63:0] act [2][8];
   int          ld  [2];
   bit          pend[2];
   logic [15:0] m_cnt[2];
   bit          m_valid[2];
   int          cyc = 0;
   bit          started = 0;
   int          r;
   bit          busy_now;

   always @(posedge clk) begin
      started = 1;
      for (int i = 0; i < 2; i++) begin
         if (!rstn) begin
            for (int k = 0; k < 8; k++) begin
               sh[i][k]  = '0;
               act[i][k] = '0;
            end
            ld[i] = -1; pend[i] = 0; m_cnt[i] = '0; m_valid[i] = 0;
         end else begin
            r = cyc - ld[i];
            if (ld[i] >= 0 && r == 0) begin
               for (int k = 0; k < 8; k++) act[i][k] = sh[i][k];
               m_cnt[i]   = m_cnt[i] + 16'd1;
               m_valid[i] = 1;
            end
            busy_now = (ld[i] >= 0) && (r >= 0) && (r <= lw_of[i] + 1 + sc_of[i]);
            if (!busy_now) begin
               if (commit[i]) ld[i] = cyc + 1;
            end else if (r == lw_of[i] + 1 + sc_of[i] && (pend[i] || commit[i])) begin
               ld[i]   = cyc + 1;
               pend[i] = 0;
            end else if (commit[i]) begin
               pend[i] = 1;
            end
            if (wr_en[i] && int'(wr_ch[i]) < nch_of[i]) sh[i][wr_ch[i]] = wr_data[i];
         end
      end
      cyc++;
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h (t=%0d)", nm, got, exp, t);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            int  rr;
            bit  e_busy, e_res, e_gate;
            rr     = cyc - ld[i];
            e_busy = (ld[i] >= 0) && (rr >= 0) && (rr <= lw_of[i] + 1 + sc_of[i]);
            e_res  = (ld[i] >= 0) && (rr == lw_of[i] + 1);
            e_gate = (ld[i] >= 0) && (rr > lw_of[i] + 1 + sc_of[i]);
            check($sformatf("m%0d.busy", i),   64'(bz[i]), 64'(e_busy));
            check($sformatf("m%0d.resync", i), 64'(rs[i]), 64'(e_res));
            check($sformatf("m%0d.gate", i),   64'(gt[i]), 64'(e_gate));
            check($sformatf("m%0d.tvalid", i), 64'(tv[i]), 64'(m_valid[i]));
            check($sformatf("m%0d.count", i),  64'(cc[i]), 64'(m_cnt[i]));
         end
         for (int k = 0; k < 8; k++)
            check($sformatf("m0.tdata[%0d]", k), tdata0[64*k +: 64], act[0][k]);
         for (int k = 0; k < 5; k++)
            check($sformatf("m1.tdata[%0d]", k), tdata1[64*k +: 64], act[1][k]);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic go_to(input int target);
      while (t < target) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rstn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wr_en[i] = 0; wr_ch[i] = '0; wr_data[i] = '0; commit[i] = 0;
      end
      repeat (3) step();
      rstn = 1'b1;

      // 1: idle after reset
      repeat (20) step();
      check("t1.tvalid", 64'(tv[0]), 64'd0);
      check("t1.busy",   64'(bz[0]), 64'd0);
      check("t1.gate",   64'(gt[0]), 64'd0);
      check("t1.count",  64'(cc[0]), 64'd0);
      check("t1.tdata",  64'(|tdata0), 64'd0);

      // 2: first commit, default timing
      wr_en[0] = 1; wr_ch[0] = 3'd0; wr_data[0] = 64'h0000_0001_0000_0100;
      step();
      wr_ch[0] = 3'd7; wr_data[0] = 64'hFFFF_0000_1234_5678;
      step();
      wr_en[0] = 0; commit[0] = 1; t = 0;
      step(); commit[0] = 0;
      check("t2.busy@1", 64'(bz[0]), 64'd1);
      check("t2.tdata_old@1", 64'(|tdata0), 64'd0);
      step();
      check("t2.ch0@2", tdata0[63:0], 64'h0000_0001_0000_0100);
      check("t2.ch7@2", tdata0[511:448], 64'hFFFF_0000_1234_5678);
      check("t2.tvalid@2", 64'(tv[0]), 64'd1);
      go_to(9);  check("t2.resync@9", 64'(rs[0]), 64'd0);
      go_to(10); check("t2.resync@10", 64'(rs[0]), 64'd1);
      go_to(11); check("t2.resync@11", 64'(rs[0]), 64'd0);
      go_to(26); check("t2.busy@26", 64'(bz[0]), 64'd1);
      check("t2.gate@26", 64'(gt[0]), 64'd0);
      go_to(27); check("t2.gate@27", 64'(gt[0]), 64'd1);
      check("t2.busy@27", 64'(bz[0]), 64'd0);
      check("t2.count", 64'(cc[0]), 64'd1);

      // 3: write+commit in RUN, then a write during LOAD
      repeat (3) step();
      wr_en[0] = 1; wr_ch[0] = 3'd3; wr_data[0] = 64'h0123_4567_89AB_CDEF;
      commit[0] = 1; t = 0;
      step(); commit[0] = 0;
      wr_data[0] = 64'hDEAD_BEEF_0000_0003;
      check("t3.gate@1", 64'(gt[0]), 64'd0);
      step(); wr_en[0] = 0;
      check("t3.ch3@2", tdata0[255:192], 64'h0123_4567_89AB_CDEF);
      go_to(26); check("t3.gate@26", 64'(gt[0]), 64'd0);
      go_to(27); check("t3.gate@27", 64'(gt[0]), 64'd1);
      check("t3.ch3@27", tdata0[255:192], 64'h0123_4567_89AB_CDEF);

      // 4: three commits while busy collapse into one extra sequence
      commit[0] = 1; t = 0;
      step(); commit[0] = 0;
      step();
      check("t4.ch3@2", tdata0[255:192], 64'hDEAD_BEEF_0000_0003);
      go_to(4);  commit[0] = 1; step(); commit[0] = 0;
      go_to(10); check("t4.resync@10", 64'(rs[0]), 64'd1);
      go_to(15); commit[0] = 1; step(); commit[0] = 0;
      go_to(20); commit[0] = 1; step(); commit[0] = 0;
      go_to(27); check("t4.busy@27", 64'(bz[0]), 64'd1);
      check("t4.gate@27", 64'(gt[0]), 64'd0);
      go_to(36); check("t4.resync@36", 64'(rs[0]), 64'd1);
      go_to(52); check("t4.gate@52", 64'(gt[0]), 64'd0);
      go_to(53); check("t4.gate@53", 64'(gt[0]), 64'd1);
      check("t4.count", 64'(cc[0]), 64'd4);
      go_to(60); check("t4.busy@60", 64'(bz[0]), 64'd0);

      // 5: reset in SETTLE with a pending commit
      commit[0] = 1; t = 0;
      step(); commit[0] = 0;
      go_to(14); commit[0] = 1; step(); commit[0] = 0;
      rstn = 1'b0;
      step();
      check("t5.tvalid", 64'(tv[0]), 64'd0);
      check("t5.gate",   64'(gt[0]), 64'd0);
      check("t5.resync", 64'(rs[0]), 64'd0);
      check("t5.busy",   64'(bz[0]), 64'd0);
      check("t5.tdata",  64'(|tdata0), 64'd0);
      check("t5.count",  64'(cc[0]), 64'd0);
      rstn = 1'b1;
      repeat (40) step();
      check("t5.no_pending", 64'(bz[0]), 64'd0);
      commit[0] = 1; t = 0;
      step(); commit[0] = 0;
      go_to(10); check("t5.resync@10", 64'(rs[0]), 64'd1);
      go_to(27); check("t5.gate@27", 64'(gt[0]), 64'd1);
      check("t5.count", 64'(cc[0]), 64'd1);

      // 6: out-of-range channels on the 5-channel instance, short timing, last-settle commit
      wr_en[0] = 1; wr_en[1] = 1;
      for (int k = 0; k < 8; k++) begin
         wr_ch[0] = 3'(k); wr_data[0] = 64'h7700_0000_0000_0000 + 64'(k * 3);
         wr_ch[1] = 3'(k); wr_data[1] = 64'h5100_0000_0000_0000 + 64'(k);
         step();
      end
      wr_en[0] = 0; wr_en[1] = 0;
      commit[0] = 1; commit[1] = 1; t = 0;
      step(); commit[0] = 0; commit[1] = 0;
      go_to(2); check("t6.resync@2", 64'(rs[1]), 64'd0);
      go_to(3); check("t6.resync@3", 64'(rs[1]), 64'd1);
      for (int k = 0; k < 5; k++)
         check($sformatf("t6.s_ch%0d", k), tdata1[64*k +: 64], 64'h5100_0000_0000_0000 + 64'(k));
      go_to(4); check("t6.gate@4", 64'(gt[1]), 64'd0);
      go_to(5); check("t6.gate@5", 64'(gt[1]), 64'd1);
      commit[1] = 1; t = 0;
      step(); commit[1] = 0;
      go_to(4); commit[1] = 1; step(); commit[1] = 0;
      check("t6.lastsettle_busy@5", 64'(bz[1]), 64'd1);
      check("t6.lastsettle_gate@5", 64'(gt[1]), 64'd0);
      step();
      check("t6.s_count@6", 64'(cc[1]), 64'd3);
      go_to(9); check("t6.gate@9", 64'(gt[1]), 64'd1);
      go_to(40);
      check("t6.d_ch7", tdata0[511:448], 64'h7700_0000_0000_0015);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
